// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int BIN_W     = 14;
  localparam int DIGITS    = 4;
  localparam int BCD_W     = 16;
  localparam int MAX_VAL   = 9999;
  localparam int SHIFT_CNT = 14;

  // Inputs above the four-digit range saturate so no digit can exceed 9.
  function automatic logic [BIN_W-1:0] clamp_bin(input logic [BIN_W-1:0] v);
    if (v > BIN_W'(MAX_VAL)) begin
      return BIN_W'(MAX_VAL);
    end
    return v;
  endfunction

endpackage

// File: rtl/bin2bcd_add3.sv
// Single-digit double-dabble correction: add 3 to any digit of 5 or more
// so that the following left shift carries correctly into the next digit.
module bcd_add3 (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // Correction applied before each shift; 9+3 = 12 still fits in 4 bits.
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= 4'd5) begin
      digit_out = digit_in + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd.sv
// Sequential 14-bit binary to 4-digit BCD converter, one bit per clock.
// Result registers only change in FINISH; done is a level held until the
// next accepted start or reset.
module bin2bcd
  import bin2bcd_pkg::*;
(
  input  logic                 clkin,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [BIN_W-1:0]     data,
  output logic [3:0]           tho,
  output logic [3:0]           hun,
  output logic [3:0]           ten,
  output logic [3:0]           uni,
  output logic                 done
);

  localparam int SR_W = BIN_W + BCD_W;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [SR_W-1:0]      shreg_q, shreg_d;
  logic [BCD_W-1:0]     result_q, result_d;
  logic                 done_q, done_d;

  logic [BCD_W-1:0]     bcd_adj;
  logic [SR_W-1:0]      shift_src;

  // Four parallel digit corrections on the scratch BCD field.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_in  (shreg_q[BIN_W + 4*gi +: 4]),
      .digit_out (bcd_adj[4*gi +: 4])
    );
  end

  assign shift_src = {bcd_adj, shreg_q[BIN_W-1:0]};

  // Next-state logic for the FSM, counter, scratch and result registers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    result_d = result_q;
    done_d   = done_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          shreg_d = {{BCD_W{1'b0}}, clamp_bin(data)};
          cnt_d   = 4'd0;
          done_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = shift_src << 1;
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'(SHIFT_CNT - 1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        result_d = shreg_q[SR_W-1:BIN_W];
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      shreg_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign tho  = result_q[15:12];
  assign hun  = result_q[11:8];
  assign ten  = result_q[7:4];
  assign uni  = result_q[3:0];
  assign done = done_q;

endmodule

// File: tb/tb_bin2bcd.sv
// Directed bench for bin2bcd: hand-computed BCD results, latency, hold and
// reset behaviour.
module tb_bin2bcd;

  logic        clkin = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [13:0] data = 14'd0;
  logic [3:0]  tho, hun, ten, uni;
  logic        done;

  int checks = 0;
  int errors = 0;

  bin2bcd dut (
    .clkin  (clkin),
    .reset  (reset),
    .enable (enable),
    .data   (data),
    .tho    (tho),
    .hun    (hun),
    .ten    (ten),
    .uni    (uni),
    .done   (done)
  );

  always #5 clkin = ~clkin;

  // Advance one rising edge and settle so outputs are sampled off the edge.
  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  // Start a conversion at E0 and follow it through E15.
  // en_mask[i] is the enable level driven before edge Ei (i = 1..15).
  // During the shifts data is scrambled to show it is not re-sampled.
  task automatic do_convert(input logic [13:0] d, input logic [15:0] exp_bcd,
                            input logic [15:0] old_bcd, input logic [15:0] en_mask,
                            input string name);
    data   = d;
    enable = 1'b1;
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s accept_done: got %b want 0", name, done);
    end
    for (int i = 1; i <= 14; i++) begin
      enable = en_mask[i];
      data   = 14'h2AAA ^ 14'(i);
      step();
      checks++;
      if (done !== 1'b0 || {tho, hun, ten, uni} !== old_bcd) begin
        errors++;
        $display("FAIL %s hold_E%0d: got done=%b bcd=%h want done=0 bcd=%h",
                 name, i, done, {tho, hun, ten, uni}, old_bcd);
      end
    end
    enable = en_mask[15];
    step();
    checks++;
    if (done !== 1'b1 || {tho, hun, ten, uni} !== exp_bcd) begin
      errors++;
      $display("FAIL %s result_E15: got done=%b bcd=%h want done=1 bcd=%h",
               name, done, {tho, hun, ten, uni}, exp_bcd);
    end
    $display("conv %s data=%0d -> bcd=%h done=%b", name, d, {tho, hun, ten, uni}, done);
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b0;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (done !== 1'b0 || {tho, hun, ten, uni} !== 16'h0000) begin
        errors++;
        $display("FAIL reset_idle: got done=%b bcd=%h want done=0 bcd=0000",
                 done, {tho, hun, ten, uni});
      end
    end
    $display("reset: bcd=%h done=%b", {tho, hun, ten, uni}, done);
  endtask

  // 2-cycle enable pulse must produce exactly one conversion.
  task automatic test_max();
    do_convert(14'd9999, 16'h9999, 16'h0000, 16'h0002, "max9999");
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (done !== 1'b1 || {tho, hun, ten, uni} !== 16'h9999) begin
        errors++;
        $display("FAIL max9999_stay: got done=%b bcd=%h want done=1 bcd=9999",
                 done, {tho, hun, ten, uni});
      end
    end
  endtask

  task automatic test_hold();
    do_convert(14'd3421, 16'h3421, 16'h9999, 16'h0000, "v3421");
    step();
  endtask

  task automatic test_zero_1000();
    do_convert(14'd0, 16'h0000, 16'h3421, 16'h0000, "v0");
    step();
    do_convert(14'd1000, 16'h1000, 16'h0000, 16'h0000, "v1000");
    step();
  endtask

  task automatic test_clamp();
    do_convert(14'd16383, 16'h9999, 16'h1000, 16'h0000, "v16383");
    step();
    do_convert(14'd10000, 16'h9999, 16'h9999, 16'h0000, "v10000");
    step();
  endtask

  task automatic test_reset_abort();
    data   = 14'd1234;
    enable = 1'b1;
    step();
    enable = 1'b0;
    for (int i = 1; i <= 6; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (done !== 1'b0 || {tho, hun, ten, uni} !== 16'h0000) begin
      errors++;
      $display("FAIL abort_E7: got done=%b bcd=%h want done=0 bcd=0000",
               done, {tho, hun, ten, uni});
    end
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (done !== 1'b0 || {tho, hun, ten, uni} !== 16'h0000) begin
      errors++;
      $display("FAIL abort_after: got done=%b bcd=%h want done=0 bcd=0000",
               done, {tho, hun, ten, uni});
    end
    $display("abort 1234 at E7: bcd=%h done=%b", {tho, hun, ten, uni}, done);
  endtask

  // Enable pulses at E3 and E8 fall in SHIFT and must not disturb latency.
  task automatic test_enable_ignored();
    do_convert(14'd42, 16'h0042, 16'h0000, 16'h0108, "v42_pulses");
    step();
  endtask

  // Enable held high: done lasts one cycle, then E16 starts the next one.
  task automatic test_back_to_back();
    do_convert(14'd58, 16'h0058, 16'h0042, 16'hFFFE, "v58_held");
    data = 14'd777;
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_E16_done: got %b want 0", done);
    end
    enable = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      step();
      checks++;
      if (done !== 1'b0 || {tho, hun, ten, uni} !== 16'h0058) begin
        errors++;
        $display("FAIL b2b_hold_%0d: got done=%b bcd=%h want done=0 bcd=0058",
                 i, done, {tho, hun, ten, uni});
      end
    end
    step();
    checks++;
    if (done !== 1'b1 || {tho, hun, ten, uni} !== 16'h0777) begin
      errors++;
      $display("FAIL b2b_result: got done=%b bcd=%h want done=1 bcd=0777",
               done, {tho, hun, ten, uni});
    end
    $display("conv v777_b2b data=777 -> bcd=%h done=%b", {tho, hun, ten, uni}, done);
  endtask

  initial begin
    test_reset();
    test_max();
    test_hold();
    test_zero_1000();
    test_clamp();
    test_reset_abort();
    test_enable_ignored();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
